// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX   = 4'd9;
    localparam bcd_t BCD_RADIX = 4'd10;

    function automatic logic digit_ok(input bcd_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit combinational BCD full adder; shared by every digit position of the serial adder.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t s,
    output logic cout
);

    logic [4:0] t_s;
    logic [4:0] adj_s;

    // Binary sum of the digits, then fold back into 0..9 when it passes the radix
    always_comb begin
        t_s   = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        adj_s = t_s - {1'b0, BCD_RADIX};
        if (t_s > {1'b0, BCD_MAX}) begin
            s    = adj_s[3:0];
            cout = 1'b1;
        end else begin
            s    = t_s[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder, one digit per clock, LSD first.
// Define BCD_SUB_EN to add the sub port and nine's-complement subtraction.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef BCD_SUB_EN
    input  logic                  sub,
`endif
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t              state_r;
    state_t              state_nx_s;
    logic [IDX_W-1:0]    idx_r;
    logic [4*DIGITS-1:0] a_r;
    logic [4*DIGITS-1:0] b_r;
    logic [4*DIGITS-1:0] sum_r;
    logic                c_r;
    logic                carry_r;
    logic                err_r;
    logic                busy_r;
    logic                done_r;
    logic                ops_ok_s;
    bcd_t                da_s;
    bcd_t                db_s;
    bcd_t                bd_s;
    bcd_t                s_s;
    logic                cout_s;
`ifdef BCD_SUB_EN
    logic                sub_r;
`endif

    // Operand validity at the moment of capture
    always_comb begin
        ops_ok_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!digit_ok(a[4*k +: 4]) || !digit_ok(b[4*k +: 4])) begin
                ops_ok_s = 1'b0;
            end else begin
                ops_ok_s = ops_ok_s;
            end
        end
    end

    // Select the current digit pair from the latched operands
    always_comb begin
        da_s = 4'd0;
        db_s = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                da_s = a_r[4*k +: 4];
                db_s = b_r[4*k +: 4];
            end else begin
                da_s = da_s;
            end
        end
    end

`ifdef BCD_SUB_EN
    assign bd_s = sub_r ? (BCD_MAX - db_s) : db_s;
`else
    assign bd_s = db_s;
`endif

    bcd_digit_add u_digit (
        .a    (da_s),
        .b    (bd_s),
        .cin  (c_r),
        .s    (s_s),
        .cout (cout_s)
    );

    // Next-state logic; an invalid capture spends one RUN cycle without computing
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (err_r || (idx_r == LAST_IDX)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            done_r  <= (state_nx_s == DONE);
        end
    end

    // Operand capture, digit iteration and result registers
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= 1'b0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
`ifdef BCD_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        idx_r   <= '0;
                        sum_r   <= '0;
                        carry_r <= 1'b0;
                        err_r   <= !ops_ok_s;
`ifdef BCD_SUB_EN
                        sub_r   <= sub;
                        c_r     <= sub;
`else
                        c_r     <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (!err_r) begin
                        for (int k = 0; k < DIGITS; k++) begin
                            if (idx_r == IDX_W'(k)) begin
                                sum_r[4*k +: 4] <= s_s;
                            end
                        end
                        c_r <= cout_s;
                        if (idx_r == LAST_IDX) begin
                            carry_r <= cout_s;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign carry = carry_r;
    assign err   = err_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4 and DIGITS=1 instances).
// Subtraction cases are exercised when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start1, sub4, sub1;
    logic [15:0] a4, b4, sum4;
    logic [3:0]  a1, b1, sum1;
    logic        busy4, done4, carry4, err4;
    logic        busy1, done1, carry1, err1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] sum;
        logic        carry;
        logic        err;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t m4, m1;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(4)) u4 (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .start    (start4),
`ifdef BCD_SUB_EN
        .sub      (sub4),
`endif
        .a        (a4),
        .b        (b4),
        .busy     (busy4),
        .done     (done4),
        .sum      (sum4),
        .carry    (carry4),
        .err      (err4)
    );

    bcd_serial_adder #(.DIGITS(1)) u1 (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .start    (start1),
`ifdef BCD_SUB_EN
        .sub      (sub1),
`endif
        .a        (a1),
        .b        (b1),
        .busy     (busy1),
        .done     (done1),
        .sum      (sum1),
        .carry    (carry1),
        .err      (err1)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Reference: decimal integers, plain arithmetic, then repacked as BCD
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s, input int d);
        exp_t r;
        int ai = 0, bi = 0, p = 1, t = 0;
        bit bad = 1'b0;
        for (int k = 0; k < d; k++) begin
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) bad = 1'b1;
            ai += int'(a[4*k +: 4]) * p;
            bi += int'(b[4*k +: 4]) * p;
            p  *= 10;
        end
        r.sum = 16'h0000; r.carry = 1'b0; r.err = bad;
        if (!bad) begin
            if (!s) begin
                t = ai + bi; r.carry = (t >= p); t = t % p;
            end else if (ai >= bi) begin
                t = ai - bi; r.carry = 1'b1;
            end else begin
                t = p - (bi - ai); r.carry = 1'b0;
            end
            for (int k = 0; k < d; k++) begin
                r.sum[4*k +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd(input int d);
        logic [15:0] v = 16'h0000;
        for (int k = 0; k < d; k++) begin
            v[4*k +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 24) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    function automatic logic rand_sub();
`ifdef BCD_SUB_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // Monitors: pop one expectation per done pulse
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                chk("u4_unexpected_done", 32'd1, 32'd0);
            end else begin
                m4 = q4.pop_front();
                chk("u4_sum", {16'h0, sum4}, {16'h0, m4.sum});
                chk("u4_carry", {31'd0, carry4}, {31'd0, m4.carry});
                chk("u4_err", {31'd0, err4}, {31'd0, m4.err});
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_done", 32'd1, 32'd0);
            end else begin
                m1 = q1.pop_front();
                chk("u1_sum", {28'h0, sum1}, {28'h0, m1.sum[3:0]});
                chk("u1_carry", {31'd0, carry1}, {31'd0, m1.carry});
                chk("u1_err", {31'd0, err1}, {31'd0, m1.err});
            end
        end
    end

    task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input logic s, input bit pulse_mid);
        exp_t e;
        int n;
        int d;
        d = (w == 4) ? 4 : 1;
        e = model(a, b, s, d);
        n = 0;
        @(negedge clk);
        while (((w == 4) ? busy4 : busy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("idle_timeout", 32'd1, 32'd0);
        if (w == 4) begin
            a4 = a; b4 = b; sub4 = s; start4 = 1'b1; q4.push_back(e);
        end else begin
            a1 = a[3:0]; b1 = b[3:0]; sub1 = s; start1 = 1'b1; q1.push_back(e);
        end
        @(posedge clk); #1;
        chk("accept_busy", {31'd0, ((w == 4) ? busy4 : busy1)}, 32'd1);
        // Operands change after acceptance and must not disturb the result
        if (w == 4) begin
            start4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); sub4 = 1'($urandom);
        end else begin
            start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); sub1 = 1'($urandom);
        end
        n = 0;
        if (pulse_mid && w == 4) begin
            @(negedge clk);
            start4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222;
            @(negedge clk);
            start4 = 1'b0;
            n = 1;
        end
        while (!((w == 4) ? done4 : done1) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, e.err ? 32'd1 : 32'(d));
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, ((w == 4) ? done4 : done1)}, 32'd0);
        chk("idle_after", {31'd0, ((w == 4) ? busy4 : busy1)}, 32'd0);
        if (w == 4) chk("hold_sum", {16'h0, sum4}, {16'h0, e.sum});
        else        chk("hold_sum", {28'h0, sum1}, {28'h0, e.sum[3:0]});
    endtask

    initial begin
        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0; sub4 = 1'b0; sub1 = 1'b0;
        a4 = 16'h0; b4 = 16'h0; a1 = 4'h0; b1 = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy4}, 32'd0);
        chk("rst_done", {31'd0, done4}, 32'd0);
        chk("rst_sum", {16'h0, sum4}, 32'd0);
        chk("rst_carry_err", {30'd0, carry4, err4}, 32'd0);
        chk("rst_u1", {26'd0, busy1, done1, sum1}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        op(4, 16'h1234, 16'h5678, 1'b0, 1'b0);
        op(4, 16'h9999, 16'h0001, 1'b0, 1'b0);
`ifdef BCD_SUB_EN
        op(4, 16'h5000, 16'h1234, 1'b1, 1'b0);
        op(4, 16'h1234, 16'h5000, 1'b1, 1'b0);
        op(4, 16'h0000, 16'h0001, 1'b1, 1'b0);
`endif
        op(4, 16'h12A4, 16'h0001, 1'b0, 1'b0);
        op(4, 16'h0042, 16'h0058, 1'b0, 1'b0);
        op(4, 16'h4321, 16'h1111, 1'b0, 1'b1);

        // Reset during RUN after digit 1 abandons the operation
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h5678; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrun_rst_busy", {31'd0, busy4}, 32'd0);
        chk("midrun_rst_done", {31'd0, done4}, 32'd0);
        chk("midrun_rst_sum", {16'h0, sum4}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 40; i++) op(4, rand_bcd(4), rand_bcd(4), rand_sub(), 1'b0);

        op(1, 16'h0007, 16'h0005, 1'b0, 1'b0);
        op(1, 16'h0009, 16'h0009, 1'b0, 1'b0);
        op(1, 16'h000B, 16'h0002, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) op(1, rand_bcd(1), rand_bcd(1), rand_sub(), 1'b0);

        repeat (10) @(posedge clk);
        #1;
        chk("u4_queue_drained", q4.size(), 32'd0);
        chk("u1_queue_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised, digit-serial N-digit BCD adder (optional subtractor) with a start/done handshake. Processes one BCD digit per clock, least-significant digit first. Replaces the fixed two-digit combinational BCD add in the keypad/seven-segment calculator path. Feeds the per-digit seven-segment decoders through a registered, stable result.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand and result; must be ≥1.
- `CLOCK_50`, in, 1: system clock; all state changes on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: request; sampled only in IDLE.
- `sub`, in, 1: 1 = subtract a−b; present only when `BCD_SUB_EN` is defined.
- `a`, in, 4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- `b`, in, 4*DIGITS: operand B, same packing.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: high for exactly one cycle when the result is valid.
- `sum`, out, 4*DIGITS: packed BCD result.
- `carry`, out, 1: decimal carry out of digit DIGITS−1; for subtract, 1 = no borrow.
- `err`, out, 1: an operand digit was > 9 at capture.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1: latch a, b and sub into internal registers. Set digit index i=0 and carry_in = sub (0 when the macro is absent). Check every latched digit.
  - Any digit > 9: go to DONE; sum=0, carry=0, err=1.
  - Otherwise: err=0; go to RUN.
- RUN, one digit per cycle:
  - bd = sub ? 9−b_i : b_i; t = a_i + bd + c (5-bit).
  - t > 9: sum_i = t−10, c=1. Else: sum_i = t, c=0.
  - i = DIGITS−1: carry = c, go to DONE. Else i++.
- DONE: done=1 for one cycle, then IDLE.
- `start` is ignored in RUN and DONE. No queuing.
- The latched operands isolate the computation. Changes on a/b/sub after acceptance have no effect.
- sum, carry and err hold their values from DONE until the next accepted start. They are not cleared on return to IDLE.
- Partial sum digits may change during RUN. Consumers qualify the result with `done` or `!busy`.
- Subtract semantics: a≥b → sum = a−b, carry=1. a<b → sum = 10^DIGITS − (b−a) (ten's complement), carry=0.
- Reset (rst_n=0 at an edge), any state including mid-RUN: state=IDLE, busy=0, done=0, sum=0, carry=0, err=0, i=0. The operation in flight is abandoned.

## Timing
- Edge E0: start accepted; busy=1 after E0.
- Valid operands: digit k is computed at edge E(k+1). After edge E(DIGITS), state=DONE and done=1. After E(DIGITS+1), state=IDLE, busy=0, done=0.
- Start-to-done latency: DIGITS edges. Earliest next start is accepted at E(DIGITS+1).
- Invalid operand: done=1 after E1; IDLE after E2.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `BCD_SUB_EN` defined: `sub` port exists; nine's-complement-plus-one subtraction as specified above.
- `BCD_SUB_EN` undefined: no `sub` port and no complement logic; add only; carry_in is always 0.

## Structure
- Package `bcd_pkg`:
  - state enum {IDLE, RUN, DONE};
  - 4-bit BCD digit typedef;
  - constants BCD_MAX=9 and BCD_RADIX=10.
- Sub-module `bcd_digit_add`: combinational one-digit BCD full adder. Inputs a, b (4 bits), cin; outputs s (4 bits), cout. Instantiated once and shared across digits through the index mux.
- Top level holds the FSM, index counter, operand/result registers and validity check.

## Test plan
- DIGITS=4, a=1234, b=5678 add → sum=6912, carry=0, err=0. done high exactly one cycle, 4 edges after start.
- 9999 + 0001 → sum=0000, carry=1. Ripple through all digits verified.
- With `BCD_SUB_EN`: 5000−1234 → sum=3766, carry=1. Then 1234−5000 → sum=6234, carry=0.
- a=12A4 (packed hex digit A) → err=1, sum=0000, carry=0; done after 1 edge. A following valid start clears err.
- rst_n low during RUN after digit 1 → next cycle busy=0, done=0, sum=0. A start pulsed while busy produces no second done.
- DIGITS=1, 7 + 5 → sum=2, carry=1, done 1 edge after start. Back-to-back start accepted at E2.
